// File: rtl/sa_pkg.sv
// Shared systolic-array constants and types: lane widths, slice sizes and the
// control bundle that travels alongside each partial-sum vector.
package sa_pkg;

    localparam int ROWS    = 8;
    localparam int PSUM_BW = 19;
    localparam int ACC_BW  = 24;

    localparam int PSUM_VEC_BW = ROWS * PSUM_BW;
    localparam int ACC_VEC_BW  = ROWS * ACC_BW;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } psum_ctrl_t;

    localparam int CTRL_BW = $bits(psum_ctrl_t);

endpackage

// File: rtl/dff.sv
// Basic register cell: async active-low reset plus synchronous clear.
module dff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state is always written with <= so every flop samples
    // the pre-edge value of its neighbours; blocking here would collapse chains.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)    q <= '0;
        else if (clr) q <= '0;
        else          q <= d;
    end

endmodule

// File: rtl/psum_skew_line.sv
// WIDTH x LEN delay line built from dff cells; LEN=0 degenerates to a wire.
module psum_skew_line #(
    parameter int WIDTH = 1,
    parameter int LEN   = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (LEN == 0) begin : g_wire
            logic unused_ok;
            assign unused_ok = ^{clk, rstn, clr};
            assign q = d;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage [LEN+1];
            assign stage[0] = d;
            for (genvar i = 0; i < LEN; i++) begin : g_stage
                dff #(.WIDTH(WIDTH)) u_dff (
                    .clk  (clk),
                    .rstn (rstn),
                    .clr  (clr),
                    .d    (stage[i]),
                    .q    (stage[i+1])
                );
            end
            assign q = stage[LEN];
        end
    endgenerate

endmodule

// File: rtl/psum_deskew_acc.sv
// MXU output stage: deskews the per-row partial sums, accumulates them across
// K-tiles into a wide bank and queues finished vectors in a show-ahead FIFO.
module psum_deskew_acc
    import sa_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [ROWS*PSUM_BW-1:0]  psum_in,
    input  logic                     in_valid,
    input  logic                     in_first,
    input  logic                     in_last,
    input  logic                     clr,
    output logic [ROWS*ACC_BW-1:0]   out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     ovf
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DEPTH - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    logic [PSUM_BW-1:0] lane_al [ROWS];
    psum_ctrl_t         ctrl_in;
    psum_ctrl_t         ctrl_al;

    // Lane r is presented r cycles late, so it waits ROWS-1-r cycles to line up.
    generate
        for (genvar r = 0; r < ROWS; r++) begin : g_lane
            psum_skew_line #(.WIDTH(PSUM_BW), .LEN(ROWS-1-r)) u_lane (
                .clk  (clk),
                .rstn (rstn),
                .clr  (1'b0),
                .d    (psum_in[r*PSUM_BW +: PSUM_BW]),
                .q    (lane_al[r])
            );
        end
    endgenerate

    assign ctrl_in = '{valid: in_valid, first: in_first, last: in_last};

    psum_skew_line #(.WIDTH(CTRL_BW), .LEN(ROWS-1)) u_ctrl (
        .clk  (clk),
        .rstn (rstn),
        .clr  (clr),
        .d    (ctrl_in),
        .q    (ctrl_al)
    );

    logic [ACC_BW-1:0] acc_mem  [DEPTH][ROWS];
    logic [ACC_BW-1:0] sum      [ROWS];
    logic [ACC_BW-1:0] fifo_mem [FIFO_DEPTH][ROWS];
    logic [IW-1:0]     idx;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              full, pop, push_req, do_push;

    // Sign-extend each lane; a first-tile vector ignores the stale entry.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            sum[r] = ACC_BW'($signed(lane_al[r])) + (ctrl_al.first ? '0 : acc_mem[idx][r]);
        end
    end

    // NOTE: the bank and FIFO storage carry a reset because their power-up
    // contents are architecturally visible (zero entries, zero out_data).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx <= '0;
            for (int d = 0; d < DEPTH; d++)
                for (int r = 0; r < ROWS; r++)
                    acc_mem[d][r] <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (ctrl_al.valid) begin
            for (int r = 0; r < ROWS; r++)
                acc_mem[idx][r] <= sum[r];
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

    assign full     = (count == CNT_FULL);
    assign out_valid = (count != '0);
    assign pop      = out_valid & out_ready;
    assign push_req = ctrl_al.valid & ctrl_al.last;
    assign do_push  = push_req & (~full | pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            for (int e = 0; e < FIFO_DEPTH; e++)
                for (int r = 0; r < ROWS; r++)
                    fifo_mem[e][r] <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) begin
                for (int r = 0; r < ROWS; r++)
                    fifo_mem[wr_ptr][r] <= sum[r];
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // The array cannot stall, so a push into a full FIFO is lost.
            if (push_req && full && !pop)
                ovf <= 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            for (int r = 0; r < ROWS; r++)
                out_data[r*ACC_BW +: ACC_BW] = fifo_mem[rd_ptr][r];
        end
    end

endmodule

// File: tb/tb_psum_deskew_acc.sv
// Directed + randomized bench for psum_deskew_acc with a cycle-level
// behavioural model: aligned vectors, accumulator bank and a FIFO queue.
module tb_psum_deskew_acc;
    import sa_pkg::*;

    localparam int DEPTH = 8;
    localparam int FD    = 4;
    localparam int MAXC  = 4096;
    localparam int VBW   = ROWS * ACC_BW;

    typedef int vec_t [ROWS];

    logic                    clk = 1'b0;
    logic                    rstn;
    logic [ROWS*PSUM_BW-1:0] psum_in;
    logic                    in_valid, in_first, in_last, clr;
    logic [VBW-1:0]          out_data;
    logic                    out_valid, out_ready, ovf;

    psum_deskew_acc #(.DEPTH(DEPTH), .FIFO_DEPTH(FD)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .psum_in   (psum_in),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_last   (in_last),
        .clr       (clr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int t     = 0;

    // Input schedule (per absolute cycle) and pending aligned vectors.
    logic [PSUM_BW-1:0] sched_lane [MAXC][ROWS];
    bit                 sched_v [MAXC], sched_f [MAXC], sched_l [MAXC];
    bit                 pend_v  [MAXC], pend_f  [MAXC], pend_l  [MAXC];
    int                 pend_lane [MAXC][ROWS];

    // Reference state.
    logic [ACC_BW-1:0] m_acc [DEPTH][ROWS];
    logic [VBW-1:0]    m_q [$];
    int                m_idx;
    bit                m_ovf;

    task automatic chk(input string tag, input logic [VBW-1:0] got, input logic [VBW-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    function automatic vec_t splat(input int v);
        vec_t x;
        for (int r = 0; r < ROWS; r++) x[r] = v;
        return x;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t x;
        for (int r = 0; r < ROWS; r++) x[r] = int'($urandom_range(0, 524287)) - 262144;
        return x;
    endfunction

    // Present a vector at the current cycle: lane r shows up r cycles later,
    // and the aligned result is due at the edge ending cycle t+ROWS-1.
    task automatic issue(input vec_t v, input bit f, input bit l);
        sched_v[t] = 1'b1;
        sched_f[t] = f;
        sched_l[t] = l;
        for (int r = 0; r < ROWS; r++) begin
            sched_lane[t+r][r]       = PSUM_BW'(v[r]);
            pend_lane[t+ROWS-1][r]   = v[r];
        end
        pend_v[t+ROWS-1] = 1'b1;
        pend_f[t+ROWS-1] = f;
        pend_l[t+ROWS-1] = l;
    endtask

    task automatic clear_model(input bit with_acc);
        m_q.delete();
        m_idx = 0;
        m_ovf = 1'b0;
        for (int c = t; c < t + ROWS && c < MAXC; c++) pend_v[c] = 1'b0;
        if (with_acc)
            for (int d = 0; d < DEPTH; d++)
                for (int r = 0; r < ROWS; r++) m_acc[d][r] = '0;
    endtask

    task automatic model_edge();
        logic [VBW-1:0]    pv;
        logic [ACC_BW-1:0] s;
        bit                push;
        bit                popped;
        if (!rstn) begin
            clear_model(1'b1);
        end else if (clr) begin
            clear_model(1'b0);
        end else begin
            push   = 1'b0;
            pv     = '0;
            popped = (m_q.size() > 0) && out_ready;
            if (pend_v[t]) begin
                for (int r = 0; r < ROWS; r++) begin
                    s = ACC_BW'(pend_lane[t][r]) + (pend_f[t] ? '0 : m_acc[m_idx][r]);
                    m_acc[m_idx][r]        = s;
                    pv[r*ACC_BW +: ACC_BW] = s;
                end
                m_idx = (m_idx + 1) % DEPTH;
                push  = pend_l[t];
            end
            if (popped) void'(m_q.pop_front());
            if (push) begin
                if (m_q.size() < FD) m_q.push_back(pv);
                else                 m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [VBW-1:0] exp_d;
        exp_d = (m_q.size() > 0) ? m_q[0] : '0;
        chk({tag, "_valid"}, VBW'(out_valid), VBW'(m_q.size() > 0));
        chk({tag, "_data"},  out_data, exp_d);
        chk({tag, "_ovf"},   VBW'(ovf), VBW'(m_ovf));
    endtask

    task automatic step();
        for (int r = 0; r < ROWS; r++) psum_in[r*PSUM_BW +: PSUM_BW] = sched_lane[t][r];
        in_valid = sched_v[t];
        in_first = sched_f[t];
        in_last  = sched_l[t];
        @(posedge clk);
        model_edge();
        #1;
        t++;
        if (t + 2*ROWS >= MAXC) begin
            $display("FAIL cycle_budget exhausted at cycle %0d", t);
            $fatal(1, "cycle budget");
        end
        check_outputs("cyc");
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [VBW-1:0] exp_v;
        bit             seen;
        int             c0;

        for (int c = 0; c < MAXC; c++)
            for (int r = 0; r < ROWS; r++) sched_lane[c][r] = PSUM_BW'($urandom);
        rstn = 1'b0; clr = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; psum_in = '0;
        clear_model(1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        rstn = 1'b1;
        steps(2);

        // Single-tile pass-through, lane r = r+1.
        c0 = t;
        issue(splat(0), 1'b1, 1'b1);
        for (int r = 0; r < ROWS; r++) sched_lane[c0+r][r] = PSUM_BW'(r + 1);
        for (int r = 0; r < ROWS; r++) pend_lane[c0+ROWS-1][r] = r + 1;
        steps(ROWS - 1);
        chk("pt_early_valid", VBW'(out_valid), '0);
        step();
        for (int r = 0; r < ROWS; r++) exp_v[r*ACC_BW +: ACC_BW] = ACC_BW'(r + 1);
        chk("pt_valid", VBW'(out_valid), VBW'(1));
        chk("pt_data", out_data, exp_v);
        steps(10);
        chk("pt_idle_valid", VBW'(out_valid), '0);

        // Negative accumulate across 3 tiles.
        pulse_clr();
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < DEPTH; j++) begin
                vec_t v;
                v    = rnd_vec();
                v[0] = -262144;
                issue(v, k == 0, k == 2);
                step();
            end
        for (int k = 0; k < DEPTH; k++) begin
            chk("neg_valid", VBW'(out_valid), VBW'(1));
            chk("neg_lane0", VBW'(out_data[ACC_BW-1:0]), VBW'(24'hF40000));
            step();
        end
        chk("neg_drained", VBW'(out_valid), '0);

        // Wrap: entry reaches 8388607 then +1 with last.
        pulse_clr();
        for (int k = 0; k < 34; k++)
            for (int j = 0; j < DEPTH; j++) begin
                vec_t v;
                v    = rnd_vec();
                v[0] = (k < 32) ? 262143 : (k == 32) ? 31 : 1;
                issue(v, k == 0, k == 33);
                step();
            end
        chk("wrap_valid", VBW'(out_valid), VBW'(1));
        chk("wrap_lane0", VBW'(out_data[ACC_BW-1:0]), VBW'(24'h800000));
        steps(12);

        // Overflow: five finished vectors into a 4-deep FIFO with no consumer.
        out_ready = 1'b0;
        pulse_clr();
        for (int k = 0; k < 5; k++) begin
            issue(splat(10 + k), 1'b1, 1'b1);
            step();
        end
        steps(10);
        chk("ovf_flag", VBW'(ovf), VBW'(1));
        out_ready = 1'b1;
        for (int k = 0; k < FD; k++) begin
            chk("ovf_pop_valid", VBW'(out_valid), VBW'(1));
            chk("ovf_pop_lane0", VBW'(out_data[ACC_BW-1:0]), VBW'(10 + k));
            step();
        end
        chk("ovf_empty", VBW'(out_valid), '0);

        // Push and pop together while full.
        out_ready = 1'b0;
        pulse_clr();
        chk("clr_ovf", VBW'(ovf), '0);
        for (int k = 0; k < FD; k++) begin
            issue(splat(20 + k), 1'b1, 1'b1);
            step();
        end
        steps(10);
        issue(splat(24), 1'b1, 1'b1);
        steps(ROWS - 1);
        out_ready = 1'b1;
        step();
        chk("pp_ovf", VBW'(ovf), '0);
        for (int k = 0; k < FD; k++) begin
            chk("pp_lane0", VBW'(out_data[ACC_BW-1:0]), VBW'(21 + k));
            step();
        end
        chk("pp_empty", VBW'(out_valid), '0);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            clr       = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 1) == 1)
                issue(rnd_vec(), $urandom_range(0, 3) == 0, $urandom_range(0, 4) < 2);
            step();
        end
        clr = 1'b0;
        out_ready = 1'b1;
        steps(15);

        // Async reset three cycles after in_valid, with a full overflowed FIFO.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            issue(splat(30 + k), 1'b1, 1'b1);
            step();
        end
        steps(10);
        issue(splat(40), 1'b1, 1'b1);
        steps(3);
        rstn = 1'b0;
        #1;
        clear_model(1'b1);
        chk("rst_now_valid", VBW'(out_valid), '0);
        chk("rst_now_data", out_data, '0);
        chk("rst_now_ovf", VBW'(ovf), '0);
        steps(2);
        rstn = 1'b1;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            seen |= out_valid;
        end
        chk("rst_no_valid", VBW'(seen), '0);

        // Same with clr.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            issue(splat(30 + k), 1'b1, 1'b1);
            step();
        end
        steps(10);
        chk("clr_pre_ovf", VBW'(ovf), VBW'(1));
        issue(splat(40), 1'b1, 1'b1);
        steps(3);
        pulse_clr();
        chk("clr_now_valid", VBW'(out_valid), '0);
        chk("clr_now_data", out_data, '0);
        chk("clr_now_ovf", VBW'(ovf), '0);
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            seen |= out_valid;
        end
        chk("clr_no_valid", VBW'(seen), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
